// File: rtl/native2axil_pkg.sv
// Shared types for the native-to-AXI4-Lite master bridge.
package native2axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_e;

    typedef enum logic {
        REQ_WR,
        REQ_RD
    } req_kind_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/native2axil.sv
// Native single-beat request to AXI4-Lite master bridge, one transaction outstanding.
// Define NATIVE2AXIL_REQ_BUF_EN to add a one-entry pending request buffer.
module native2axil
    import native2axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESET,
    output logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
    output logic [2:0]              AXI_AWPROT,
    output logic                    AXI_AWVALID,
    input  logic                    AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
    output logic                    AXI_WVALID,
    input  logic                    AXI_WREADY,
    input  logic [1:0]              AXI_BRESP,
    input  logic                    AXI_BVALID,
    output logic                    AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
    output logic [2:0]              AXI_ARPROT,
    output logic                    AXI_ARVALID,
    input  logic                    AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]              AXI_RRESP,
    input  logic                    AXI_RVALID,
    output logic                    AXI_RREADY,
    input  logic                    WEN,
    input  logic [ADDR_WIDTH-1:0]   WADDR,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic                    REN,
    input  logic [ADDR_WIDTH-1:0]   RADDR,
    output logic                    BUSY,
    output logic                    WACK,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic                    RVALID,
    output logic                    ERR,
    output logic                    DROP
);

    state_e                 state, state_n;
    logic                   aw_vld, aw_vld_n, w_vld, w_vld_n, ar_vld, ar_vld_n;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_n;
    logic [DATA_WIDTH-1:0]  data_q, data_n, rdata_q, rdata_n;
    logic                   wack_q, wack_n, rvalid_q, rvalid_n, err_q, err_n, drop_q, drop_n;

    // Incoming request (write wins) and the request chosen for issue this cycle
    logic                   req_vld;
    req_kind_e              req_kind;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic                   iss_vld;
    req_kind_e              iss_kind;
    logic [ADDR_WIDTH-1:0]  iss_addr;
    logic [DATA_WIDTH-1:0]  iss_data;

`ifdef NATIVE2AXIL_REQ_BUF_EN
    logic                   buf_vld, buf_vld_n;
    req_kind_e              buf_kind, buf_kind_n;
    logic [ADDR_WIDTH-1:0]  buf_addr, buf_addr_n;
    logic [DATA_WIDTH-1:0]  buf_data, buf_data_n;
`endif

    assign req_vld  = WEN | REN;
    assign req_kind = WEN ? REQ_WR : REQ_RD;
    assign req_addr = WEN ? WADDR : RADDR;

    always_comb begin
        state_n  = state;
        aw_vld_n = aw_vld;
        w_vld_n  = w_vld;
        ar_vld_n = ar_vld;
        addr_n   = addr_q;
        data_n   = data_q;
        rdata_n  = rdata_q;
        wack_n   = 1'b0;
        rvalid_n = 1'b0;
        err_n    = 1'b0;
        drop_n   = 1'b0;
        iss_vld  = 1'b0;
        iss_kind = REQ_WR;
        iss_addr = addr_q;
        iss_data = data_q;
`ifdef NATIVE2AXIL_REQ_BUF_EN
        buf_vld_n  = buf_vld;
        buf_kind_n = buf_kind;
        buf_addr_n = buf_addr;
        buf_data_n = buf_data;
`endif

        case (state)
            WR_REQ: begin
                if (AXI_AWREADY) aw_vld_n = 1'b0;
                if (AXI_WREADY)  w_vld_n  = 1'b0;
                if ((!aw_vld || AXI_AWREADY) && (!w_vld || AXI_WREADY)) state_n = WR_RESP;
            end
            WR_RESP: if (AXI_BVALID) begin
                wack_n  = 1'b1;
                err_n   = (AXI_BRESP != AXI_RESP_OKAY);
                state_n = IDLE;
            end
            RD_REQ: if (AXI_ARREADY) begin
                ar_vld_n = 1'b0;
                state_n  = RD_RESP;
            end
            RD_RESP: if (AXI_RVALID) begin
                rdata_n  = AXI_RDATA;
                rvalid_n = 1'b1;
                err_n    = (AXI_RRESP != AXI_RESP_OKAY);
                state_n  = IDLE;
            end
            default: ;
        endcase

`ifdef NATIVE2AXIL_REQ_BUF_EN
        // A parked request goes first; the slot it frees can take a new one
        if (state == IDLE && buf_vld) begin
            iss_vld   = 1'b1;
            iss_kind  = buf_kind;
            iss_addr  = buf_addr;
            iss_data  = buf_data;
            buf_vld_n = req_vld;
            if (req_vld) begin
                buf_kind_n = req_kind;
                buf_addr_n = req_addr;
                buf_data_n = WDATA;
                drop_n     = WEN & REN;
            end
        end else if (state == IDLE) begin
            iss_vld  = req_vld;
            iss_kind = req_kind;
            iss_addr = req_addr;
            iss_data = WDATA;
            if (WEN && REN) begin
                buf_vld_n  = 1'b1;
                buf_kind_n = REQ_RD;
                buf_addr_n = RADDR;
            end
        end else if (req_vld) begin
            if (!buf_vld) begin
                buf_vld_n  = 1'b1;
                buf_kind_n = req_kind;
                buf_addr_n = req_addr;
                buf_data_n = WDATA;
                drop_n     = WEN & REN;
            end else begin
                drop_n = 1'b1;
            end
        end
`else
        if (state == IDLE) begin
            iss_vld  = req_vld;
            iss_kind = req_kind;
            iss_addr = req_addr;
            iss_data = WDATA;
            drop_n   = WEN & REN;
        end else begin
            drop_n = req_vld;
        end
`endif

        // One address/data register serves both directions
        if (iss_vld) begin
            addr_n = iss_addr;
            data_n = iss_data;
            if (iss_kind == REQ_WR) begin
                state_n  = WR_REQ;
                aw_vld_n = 1'b1;
                w_vld_n  = 1'b1;
            end else begin
                state_n  = RD_REQ;
                ar_vld_n = 1'b1;
            end
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state    <= IDLE;
            aw_vld   <= 1'b0;
            w_vld    <= 1'b0;
            ar_vld   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            wack_q   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
`ifdef NATIVE2AXIL_REQ_BUF_EN
            buf_vld  <= 1'b0;
            buf_kind <= REQ_WR;
            buf_addr <= '0;
            buf_data <= '0;
`endif
        end else begin
            state    <= state_n;
            aw_vld   <= aw_vld_n;
            w_vld    <= w_vld_n;
            ar_vld   <= ar_vld_n;
            addr_q   <= addr_n;
            data_q   <= data_n;
            rdata_q  <= rdata_n;
            wack_q   <= wack_n;
            rvalid_q <= rvalid_n;
            err_q    <= err_n;
            drop_q   <= drop_n;
`ifdef NATIVE2AXIL_REQ_BUF_EN
            buf_vld  <= buf_vld_n;
            buf_kind <= buf_kind_n;
            buf_addr <= buf_addr_n;
            buf_data <= buf_data_n;
`endif
        end
    end

    assign AXI_AWADDR  = addr_q;
    assign AXI_ARADDR  = addr_q;
    assign AXI_WDATA   = data_q;
    assign AXI_AWPROT  = 3'b000;
    assign AXI_ARPROT  = 3'b000;
    assign AXI_WSTRB   = '1;
    assign AXI_AWVALID = aw_vld;
    assign AXI_WVALID  = w_vld;
    assign AXI_ARVALID = ar_vld;
    assign AXI_BREADY  = (state == WR_RESP);
    assign AXI_RREADY  = (state == RD_RESP);
    assign BUSY        = (state != IDLE);
    assign WACK        = wack_q;
    assign RVALID      = rvalid_q;
    assign RDATA       = rdata_q;
    assign ERR         = err_q;
    assign DROP        = drop_q;

endmodule

// File: tb/tb_native2axil.sv
// Bench for native2axil: latency-based reference model plus a scripted AXI4-Lite slave.
module tb_native2axil;

    logic        AXI_ACLK = 1'b0;
    logic        AXI_ARESET;
    logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA, WADDR, WDATA, RADDR, RDATA;
    logic [2:0]  AXI_AWPROT, AXI_ARPROT;
    logic [3:0]  AXI_WSTRB;
    logic [1:0]  AXI_BRESP, AXI_RRESP;
    logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY, AXI_BVALID, AXI_BREADY;
    logic        AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
    logic        WEN, REN, BUSY, WACK, RVALID, ERR, DROP;

    always #5 AXI_ACLK = ~AXI_ACLK;

    native2axil dut (
        .AXI_ACLK(AXI_ACLK), .AXI_ARESET(AXI_ARESET),
        .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARADDR(AXI_ARADDR), .AXI_ARPROT(AXI_ARPROT), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
        .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA), .REN(REN), .RADDR(RADDR),
        .BUSY(BUSY), .WACK(WACK), .RDATA(RDATA), .RVALID(RVALID), .ERR(ERR), .DROP(DROP)
    );

    // One transaction: request contents plus the slave's delays and response
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          da;
        int          dw;
        int          db;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } txn_t;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    txn_t        ovr[$], sq[$];
    bit          m_act = 0, m_drop = 0;
    int          m_done = 0;
    txn_t        m_t;
    logic [31:0] m_rhold = '0;
    bit          b_vld = 0, b_wr = 0;
    logic [31:0] b_addr = '0, b_data = '0;
    bit          s_act = 0, s_ad = 0, s_wd = 0, s_ph2 = 0;
    int          s_ac = 0, s_wc = 0, s_rc = 0;
    txn_t        s_t;

    task automatic force_txn(int da, int dw, int db, logic [1:0] resp, logic [31:0] rd);
        txn_t o;
        o.wr = 0; o.addr = '0; o.data = '0;
        o.da = da; o.dw = dw; o.db = db; o.resp = resp; o.rdata = rd;
        ovr.push_back(o);
    endtask

    // Completion appears 3 cycles after the request plus all slave wait cycles
    task automatic issue(bit wr, logic [31:0] a, logic [31:0] d);
        txn_t t;
        if (ovr.size() > 0) t = ovr.pop_front();
        else begin
            t.da = $urandom_range(0, 3); t.dw = $urandom_range(0, 3); t.db = $urandom_range(0, 3);
            t.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            t.rdata = $urandom;
        end
        t.wr = wr; t.addr = a; t.data = d;
        m_act  = 1;
        m_t    = t;
        m_done = cyc + 3 + t.db + (wr ? ((t.da > t.dw) ? t.da : t.dw) : t.da);
        sq.push_back(t);
    endtask

    task automatic slave_cycle();
        AXI_AWREADY = 0; AXI_WREADY = 0; AXI_BVALID = 0; AXI_ARREADY = 0; AXI_RVALID = 0;
        AXI_BRESP = 2'($urandom); AXI_RRESP = 2'($urandom); AXI_RDATA = $urandom;
        if (!s_act && sq.size() == 0) begin
            chk("idle_awvalid", AXI_AWVALID, 0); chk("idle_wvalid", AXI_WVALID, 0);
            chk("idle_arvalid", AXI_ARVALID, 0); chk("idle_bready", AXI_BREADY, 0);
            chk("idle_rready", AXI_RREADY, 0);
        end else if (!s_act) begin
            s_t = sq.pop_front();
            s_act = 1; s_ad = 0; s_wd = 0; s_ph2 = 0; s_ac = 0; s_wc = 0; s_rc = 0;
            chk("start_awvalid", AXI_AWVALID, s_t.wr); chk("start_wvalid", AXI_WVALID, s_t.wr);
            chk("start_arvalid", AXI_ARVALID, !s_t.wr);
        end
        if (!s_act) return;
        if (s_t.wr && !s_ph2) begin
            chk("bready_early", AXI_BREADY, 0);
            if (!s_ad) begin
                chk("awvalid_hold", AXI_AWVALID, 1); chk("awaddr", AXI_AWADDR, s_t.addr);
                chk("awprot", AXI_AWPROT, 0);
                if (s_ac == s_t.da) begin AXI_AWREADY = 1; s_ad = 1; end else s_ac++;
            end else chk("awvalid_drop", AXI_AWVALID, 0);
            if (!s_wd) begin
                chk("wvalid_hold", AXI_WVALID, 1); chk("wdata", AXI_WDATA, s_t.data);
                chk("wstrb", AXI_WSTRB, 4'hF);
                if (s_wc == s_t.dw) begin AXI_WREADY = 1; s_wd = 1; end else s_wc++;
            end else chk("wvalid_drop", AXI_WVALID, 0);
            if (s_ad && s_wd) s_ph2 = 1;
        end else if (s_t.wr) begin
            chk("bready", AXI_BREADY, 1);
            chk("b_awvalid", AXI_AWVALID, 0); chk("b_wvalid", AXI_WVALID, 0);
            if (s_rc == s_t.db) begin AXI_BVALID = 1; AXI_BRESP = s_t.resp; s_act = 0; end else s_rc++;
        end else if (!s_ph2) begin
            chk("arvalid_hold", AXI_ARVALID, 1); chk("araddr", AXI_ARADDR, s_t.addr);
            chk("arprot", AXI_ARPROT, 0); chk("rready_early", AXI_RREADY, 0);
            if (s_ac == s_t.da) begin AXI_ARREADY = 1; s_ph2 = 1; end else s_ac++;
        end else begin
            chk("rready", AXI_RREADY, 1); chk("r_arvalid", AXI_ARVALID, 0);
            if (s_rc == s_t.db) begin
                AXI_RVALID = 1; AXI_RDATA = s_t.rdata; AXI_RRESP = s_t.resp; s_act = 0;
            end else s_rc++;
        end
    endtask

    task automatic step(bit rst, bit wen, bit ren, logic [31:0] wa, logic [31:0] wd, logic [31:0] ra);
        bit ack;
        ack = m_act && (cyc == m_done);
        chk("busy", BUSY, m_act && !ack);
        chk("wack", WACK, ack && m_t.wr);
        chk("rvalid", RVALID, ack && !m_t.wr);
        chk("err", ERR, ack && (m_t.resp != 2'b00));
        if (ack && !m_t.wr) m_rhold = m_t.rdata;
        chk("rdata", RDATA, m_rhold);
        chk("drop", DROP, m_drop);
        if (ack) m_act = 0;
        slave_cycle();
        m_drop = 0;
        if (rst) begin
            m_act = 0; b_vld = 0; m_rhold = '0; s_act = 0; sq.delete();
        end else if (!m_act) begin
`ifdef NATIVE2AXIL_REQ_BUF_EN
            if (b_vld) begin
                issue(b_wr, b_addr, b_data);
                b_vld = wen || ren;
                b_wr = wen; b_addr = wen ? wa : ra; b_data = wd;
                m_drop = wen && ren;
            end else if (wen) begin
                issue(1, wa, wd);
                if (ren) begin b_vld = 1; b_wr = 0; b_addr = ra; b_data = wd; end
            end else if (ren) issue(0, ra, wd);
`else
            if (wen) begin issue(1, wa, wd); m_drop = ren; end
            else if (ren) issue(0, ra, wd);
`endif
        end else if (wen || ren) begin
`ifdef NATIVE2AXIL_REQ_BUF_EN
            if (!b_vld) begin
                b_vld = 1; b_wr = wen; b_addr = wen ? wa : ra; b_data = wd;
                m_drop = wen && ren;
            end else m_drop = 1;
`else
            m_drop = 1;
`endif
        end
        AXI_ARESET = rst; WEN = wen; REN = ren; WADDR = wa; WDATA = wd; RADDR = ra;
        @(posedge AXI_ACLK);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, $urandom, $urandom, $urandom);
    endtask

    initial begin
        AXI_ARESET = 1; WEN = 0; REN = 0; WADDR = '0; WDATA = '0; RADDR = '0;
        AXI_AWREADY = 0; AXI_WREADY = 0; AXI_BVALID = 0; AXI_BRESP = '0;
        AXI_ARREADY = 0; AXI_RVALID = 0; AXI_RDATA = '0; AXI_RRESP = '0;
        repeat (3) @(posedge AXI_ACLK);
        #1;
        chk("rst_awvalid", AXI_AWVALID, 0); chk("rst_wvalid", AXI_WVALID, 0);
        chk("rst_arvalid", AXI_ARVALID, 0); chk("rst_bready", AXI_BREADY, 0);
        chk("rst_rready", AXI_RREADY, 0);

        // zero-wait write
        force_txn(0, 0, 0, 2'b00, 0);
        step(0, 1, 0, 32'h10, 32'hDEADBEEF, 0);
        idle(6);
        // read with ARREADY after 3 cycles and SLVERR
        ovr.delete(); force_txn(3, 0, 0, 2'b10, 32'h12345678);
        step(0, 0, 1, 0, 0, 32'h20);
        idle(10);
        // WREADY two cycles before AWREADY
        ovr.delete(); force_txn(2, 0, 0, 2'b00, 0);
        step(0, 1, 0, 32'h30, 32'hCAFEF00D, 0);
        idle(8);
        // simultaneous WEN and REN
        ovr.delete(); force_txn(0, 0, 0, 2'b00, 0); force_txn(0, 0, 0, 2'b00, 32'hA5A50F0F);
        step(0, 1, 1, 32'h40, 32'h11112222, 32'h44);
        idle(14);
        // three WENs while busy
        ovr.delete(); force_txn(0, 0, 4, 2'b00, 0); force_txn(0, 0, 0, 2'b00, 0);
        step(0, 1, 0, 32'h50, 32'h1, 0);
        step(0, 1, 0, 32'h54, 32'h2, 0);
        step(0, 1, 0, 32'h58, 32'h3, 0);
        step(0, 1, 0, 32'h5C, 32'h4, 0);
        idle(20);
        // reset while waiting for BVALID
        ovr.delete(); force_txn(0, 0, 5, 2'b00, 0);
        step(0, 1, 0, 32'h60, 32'h77, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0);
        chk("midrst_bready", AXI_BREADY, 0); chk("midrst_busy", BUSY, 0);
        chk("midrst_awvalid", AXI_AWVALID, 0); chk("midrst_wvalid", AXI_WVALID, 0);
        idle(10);

        ovr.delete();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom, $urandom, $urandom);
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
